// File: rtl/core_lsu_arbiter.sv
// Round-robin arbiter sharing the single-port L1 core local memory among the core's LSUs.
// A response watchdog forces an error completion if the L1 never answers.
module core_lsu_arbiter #(
    parameter int NUM_THREADS    = 4,
    parameter int ADDR_WIDTH     = 15,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_THREADS-1:0]            lsu_read_valid,
    input  logic [NUM_THREADS*ADDR_WIDTH-1:0] lsu_read_address,
    input  logic [NUM_THREADS-1:0]            lsu_write_valid,
    input  logic [NUM_THREADS*ADDR_WIDTH-1:0] lsu_write_address,
    input  logic [NUM_THREADS*DATA_WIDTH-1:0] lsu_write_data,
    output logic [NUM_THREADS-1:0]            lsu_read_ready,
    output logic [NUM_THREADS*DATA_WIDTH-1:0] lsu_read_data,
    output logic [NUM_THREADS-1:0]            lsu_write_ready,
    output logic                              mem_read_valid,
    output logic [ADDR_WIDTH-1:0]             mem_read_address,
    output logic                              mem_write_valid,
    output logic [ADDR_WIDTH-1:0]             mem_write_address,
    output logic [DATA_WIDTH-1:0]             mem_write_data,
    input  logic                              mem_read_ready,
    input  logic [DATA_WIDTH-1:0]             mem_read_data,
    input  logic                              mem_write_ready,
    output logic                              busy,
    output logic                              timeout_error
);

    localparam int         PTR_W         = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   winner;
    logic               op_write;
    logic [7:0]         watchdog;
    logic [NUM_THREADS-1:0] req;
    logic               grant_found;
    logic [PTR_W-1:0]   grant_idx;

    assign req  = lsu_read_valid | lsu_write_valid;
    assign busy = (state != IDLE);

    // First requester found scanning upward from rr_ptr, wrapping at NUM_THREADS.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < NUM_THREADS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_THREADS) begin
                idx = idx - NUM_THREADS;
            end
            if (!grant_found && req[idx]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            rr_ptr            <= '0;
            winner            <= '0;
            op_write          <= 1'b0;
            watchdog          <= '0;
            lsu_read_ready    <= '0;
            lsu_write_ready   <= '0;
            lsu_read_data     <= '0;
            mem_read_valid    <= 1'b0;
            mem_read_address  <= '0;
            mem_write_valid   <= 1'b0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
            timeout_error     <= 1'b0;
        end else begin
            mem_read_valid  <= 1'b0;
            mem_write_valid <= 1'b0;
            lsu_read_ready  <= '0;
            lsu_write_ready <= '0;

            case (state)
                // A thread with both valids gets its write first; the read re-arbitrates later.
                IDLE: begin
                    if (grant_found) begin
                        winner   <= grant_idx;
                        op_write <= lsu_write_valid[grant_idx];
                        rr_ptr   <= (grant_idx == PTR_W'(NUM_THREADS - 1)) ? '0 : grant_idx + 1'b1;
                        if (lsu_write_valid[grant_idx]) begin
                            mem_write_valid   <= 1'b1;
                            mem_write_address <= lsu_write_address[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                            mem_write_data    <= lsu_write_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                        end else begin
                            mem_read_valid    <= 1'b1;
                            mem_read_address  <= lsu_read_address[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        end
                        state <= ISSUE;
                    end
                end

                ISSUE: begin
                    watchdog <= '0;
                    state    <= WAIT;
                end

                // Only the ready matching the issued op counts; the watchdog bounds the wait.
                WAIT: begin
                    if (op_write ? mem_write_ready : mem_read_ready) begin
                        if (op_write) begin
                            lsu_write_ready[winner] <= 1'b1;
                        end else begin
                            lsu_read_ready[winner]                            <= 1'b1;
                            lsu_read_data[winner*DATA_WIDTH +: DATA_WIDTH] <= mem_read_data;
                        end
                        state <= DONE;
                    end else if (watchdog + 8'd1 == TIMEOUT_LIMIT) begin
                        timeout_error <= 1'b1;
                        if (op_write) begin
                            lsu_write_ready[winner] <= 1'b1;
                        end else begin
                            lsu_read_ready[winner]                            <= 1'b1;
                            lsu_read_data[winner*DATA_WIDTH +: DATA_WIDTH] <= '0;
                        end
                        state <= DONE;
                    end else begin
                        watchdog <= watchdog + 8'd1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_lsu_arbiter.sv
// Bench for core_lsu_arbiter: table-driven single transactions, hand-written corner sequences
// and randomized request rounds checked against a transaction-level arbitration model.
module tb_core_lsu_arbiter;

    localparam int NT = 4;
    localparam int AW = 15;
    localparam int DW = 8;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NT-1:0]     lsu_read_valid, lsu_write_valid, lsu_read_ready, lsu_write_ready;
    logic [NT*AW-1:0]  lsu_read_address, lsu_write_address;
    logic [NT*DW-1:0]  lsu_write_data, lsu_read_data;
    logic              mem_read_valid, mem_write_valid, mem_read_ready, mem_write_ready;
    logic [AW-1:0]     mem_read_address, mem_write_address;
    logic [DW-1:0]     mem_write_data, mem_read_data;
    logic              busy, timeout_error;

    // L1 model state: unwritten locations read as 0x10 + low address byte
    logic [DW-1:0]     l1 [0:(1<<AW)-1];
    bit                l1_written [0:(1<<AW)-1];
    logic              l1_rr = 1'b0;
    logic              l1_wr = 1'b0;
    logic [DW-1:0]     l1_rd = '0;
    logic              withhold_read = 1'b0;
    logic              stray_rr = 1'b0;

    logic [DW-1:0]     ref_mem [int];
    int                model_ptr;
    logic [AW-1:0]     rnd_raddr [NT];
    logic [AW-1:0]     rnd_waddr [NT];
    logic [DW-1:0]     rnd_wdata [NT];

    int                exp_n;
    int                exp_thr   [16];
    bit                exp_wr    [16];
    logic [AW-1:0]     exp_addr  [16];
    logic [DW-1:0]     exp_wdata [16];
    logic [DW-1:0]     exp_rdata [16];

    int                checks = 0;
    int                passes = 0;

    typedef struct {
        int            thread;
        bit            is_write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } test_vec_t;

    always #5 clk = ~clk;

    core_lsu_arbiter dut (
        .clk               (clk),
        .reset             (reset),
        .lsu_read_valid    (lsu_read_valid),
        .lsu_read_address  (lsu_read_address),
        .lsu_write_valid   (lsu_write_valid),
        .lsu_write_address (lsu_write_address),
        .lsu_write_data    (lsu_write_data),
        .lsu_read_ready    (lsu_read_ready),
        .lsu_read_data     (lsu_read_data),
        .lsu_write_ready   (lsu_write_ready),
        .mem_read_valid    (mem_read_valid),
        .mem_read_address  (mem_read_address),
        .mem_write_valid   (mem_write_valid),
        .mem_write_address (mem_write_address),
        .mem_write_data    (mem_write_data),
        .mem_read_ready    (mem_read_ready),
        .mem_read_data     (mem_read_data),
        .mem_write_ready   (mem_write_ready),
        .busy              (busy),
        .timeout_error     (timeout_error)
    );

    // Single-port L1 with one-cycle registered ready; reads can be withheld to exercise the watchdog.
    always @(posedge clk) begin
        l1_rr <= 1'b0;
        l1_wr <= 1'b0;
        if (mem_read_valid && !withhold_read) begin
            l1_rr <= 1'b1;
            l1_rd <= l1_written[mem_read_address] ? l1[mem_read_address] : 8'h10 + mem_read_address[7:0];
        end
        if (mem_write_valid) begin
            l1[mem_write_address]         <= mem_write_data;
            l1_written[mem_write_address] <= 1'b1;
            l1_wr                         <= 1'b1;
        end
    end

    assign mem_read_ready  = l1_rr | stray_rr;
    assign mem_read_data   = l1_rd;
    assign mem_write_ready = l1_wr;

    function automatic logic [DW-1:0] refRead(input logic [AW-1:0] addr);
        return ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : 8'h10 + addr[7:0];
    endfunction

    function automatic logic [AW-1:0] pickAddr();
        if ($urandom_range(0, 1) == 0) return 15'($urandom_range(0, 7));
        return 15'h7FF8 + 15'($urandom_range(0, 7));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int t, input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        if (wr) begin
            lsu_write_valid[t]            = 1'b1;
            lsu_write_address[t*AW +: AW] = addr;
            lsu_write_data[t*DW +: DW]    = data;
        end else begin
            lsu_read_valid[t]             = 1'b1;
            lsu_read_address[t*AW +: AW]  = addr;
        end
    endtask

    task automatic expectTxn(input int t, input bit wr, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input logic [DW-1:0] rdata);
        exp_thr[exp_n]   = t;
        exp_wr[exp_n]    = wr;
        exp_addr[exp_n]  = addr;
        exp_wdata[exp_n] = wdata;
        exp_rdata[exp_n] = rdata;
        exp_n++;
    endtask

    task automatic doReset();
        reset           = 1'b1;
        lsu_read_valid  = '0;
        lsu_write_valid = '0;
        repeat (2) @(negedge clk);
        reset           = 1'b0;
    endtask

    // Arbitration order from the rules alone: circular scan from the pointer, writes before reads.
    task automatic modelRound(input logic [NT-1:0] rm, input logic [NT-1:0] wm);
        logic [NT-1:0] pr, pw;
        int            t;
        pr    = rm;
        pw    = wm;
        exp_n = 0;
        while ((pr | pw) != '0) begin
            t = model_ptr;
            while (!(pr[t] || pw[t])) t = (t + 1) % NT;
            if (pw[t]) begin
                ref_mem[int'(rnd_waddr[t])] = rnd_wdata[t];
                expectTxn(t, 1'b1, rnd_waddr[t], rnd_wdata[t], 8'h00);
                pw[t] = 1'b0;
            end else begin
                expectTxn(t, 1'b0, rnd_raddr[t], 8'h00, refRead(rnd_raddr[t]));
                pr[t] = 1'b0;
            end
            model_ptr = (t + 1) % NT;
        end
    endtask

    // Expected transactions complete back to back: strobe at phase 1, LSU ready at phase 3.
    task automatic runSequence(input int n, input bit rearm);
        int last_t;
        bit last_wr;
        last_t  = 0;
        last_wr = 1'b0;
        for (int j = 1; j <= 4 * n; j++) begin
            int          k, ph;
            logic [10:0] ev, av;
            @(negedge clk);
            k  = j / 4;
            ph = j % 4;
            ev = '0;
            if (ph != 0) ev[10] = 1'b1;
            if (ph == 1) ev[1:0] = exp_wr[k] ? 2'b01 : 2'b10;
            if (ph == 3) begin
                if (exp_wr[k]) ev[2 + exp_thr[k]] = 1'b1;
                else           ev[6 + exp_thr[k]] = 1'b1;
            end
            av = {busy, lsu_read_ready, lsu_write_ready, mem_read_valid, mem_write_valid};
            checkOutput($sformatf("outputs_cycle%0d", j), 32'(av), 32'(ev));
            if (ph == 1) begin
                checkOutput($sformatf("strobe_addr_data_txn%0d", k),
                            exp_wr[k] ? {mem_write_address, mem_write_data} : {mem_read_address, 8'h00},
                            {exp_addr[k], exp_wr[k] ? exp_wdata[k] : 8'h00});
            end
            if (ph == 3) begin
                if (!exp_wr[k]) begin
                    checkOutput($sformatf("read_data_t%0d_txn%0d", exp_thr[k], k),
                                32'(lsu_read_data[exp_thr[k]*DW +: DW]), 32'(exp_rdata[k]));
                end
                last_t  = exp_thr[k];
                last_wr = exp_wr[k];
                if (exp_wr[k]) lsu_write_valid[exp_thr[k]] = 1'b0;
                else           lsu_read_valid[exp_thr[k]]  = 1'b0;
            end
            if (ph == 0 && rearm) begin
                if (last_wr) lsu_write_valid[last_t] = 1'b1;
                else         lsu_read_valid[last_t]  = 1'b1;
            end
        end
    endtask

    initial begin
        test_vec_t     vecs [6];
        int            bad;
        logic [NT-1:0] rm, wm;

        vecs[0] = '{2, 1'b1, 15'h0010, 8'hA5, 8'h00};
        vecs[1] = '{2, 1'b0, 15'h0010, 8'h00, 8'hA5};
        vecs[2] = '{0, 1'b0, 15'h0003, 8'h00, 8'h13};
        vecs[3] = '{3, 1'b1, 15'h0020, 8'h5E, 8'h00};
        vecs[4] = '{1, 1'b0, 15'h0020, 8'h00, 8'h5E};
        vecs[5] = '{3, 1'b0, 15'h0001, 8'h00, 8'h11};

        lsu_read_address  = '0;
        lsu_write_address = '0;
        lsu_write_data    = '0;
        doReset();
        checkOutput("reset_ctrl", {busy, timeout_error, mem_read_valid, mem_write_valid, lsu_read_ready, lsu_write_ready}, 0);
        checkOutput("reset_read_data", lsu_read_data, 0);
        checkOutput("reset_mem_bus", {mem_read_address, mem_write_address}, 0);

        $display("[TB] all four threads read from reset");
        exp_n = 0;
        for (int t = 0; t < NT; t++) begin
            applyStimulus(t, 1'b0, 15'(t), 8'h00);
            expectTxn(t, 1'b0, 15'(t), 8'h00, 8'h10 + 8'(t));
        end
        runSequence(4, 1'b0);
        checkOutput("slices_hold_own_byte", lsu_read_data, 32'h13121110);

        $display("[TB] table-driven single transactions");
        for (int v = 0; v < 6; v++) begin
            exp_n = 0;
            applyStimulus(vecs[v].thread, vecs[v].is_write, vecs[v].addr, vecs[v].wdata);
            expectTxn(vecs[v].thread, vecs[v].is_write, vecs[v].addr, vecs[v].wdata, vecs[v].rdata);
            if (vecs[v].is_write) ref_mem[int'(vecs[v].addr)] = vecs[v].wdata;
            runSequence(1, 1'b0);
        end

        $display("[TB] thread 1 read and write together");
        exp_n = 0;
        applyStimulus(1, 1'b1, 15'h7FFF, 8'h3C);
        applyStimulus(1, 1'b0, 15'h7FFF, 8'h00);
        expectTxn(1, 1'b1, 15'h7FFF, 8'h3C, 8'h00);
        expectTxn(1, 1'b0, 15'h7FFF, 8'h00, 8'h3C);
        ref_mem[32'h7FFF] = 8'h3C;
        runSequence(2, 1'b0);

        $display("[TB] watchdog on withheld read");
        withhold_read = 1'b1;
        applyStimulus(0, 1'b0, 15'h0005, 8'h00);
        bad = 0;
        for (int j = 1; j <= 2 + TO; j++) begin
            @(negedge clk);
            if (j < 2 + TO && (lsu_read_ready != '0 || timeout_error)) bad++;
        end
        checkOutput("timeout_no_early_completion", bad, 0);
        checkOutput("timeout_ready_pulse", 32'(lsu_read_ready), 32'b0001);
        checkOutput("timeout_data_forced_zero", 32'(lsu_read_data[7:0]), 0);
        checkOutput("timeout_error_set", 32'(timeout_error), 1);
        lsu_read_valid[0] = 1'b0;
        withhold_read     = 1'b0;
        @(negedge clk);
        checkOutput("timeout_back_idle", {busy, lsu_read_ready, timeout_error}, 32'b0_0000_1);
        exp_n = 0;
        applyStimulus(1, 1'b0, 15'h7FFF, 8'h00);
        expectTxn(1, 1'b0, 15'h7FFF, 8'h00, 8'h3C);
        runSequence(1, 1'b0);
        checkOutput("timeout_error_sticky", 32'(timeout_error), 1);
        doReset();
        checkOutput("timeout_error_cleared", 32'(timeout_error), 0);

        $display("[TB] reset during WAIT");
        withhold_read = 1'b1;
        applyStimulus(2, 1'b0, 15'h0010, 8'h00);
        repeat (2) @(negedge clk);
        checkOutput("rst_wait_busy_before", 32'(busy), 1);
        reset          = 1'b1;
        lsu_read_valid = '0;
        @(negedge clk);
        checkOutput("rst_wait_abort", {busy, lsu_read_ready, lsu_write_ready}, 0);
        reset         = 1'b0;
        withhold_read = 1'b0;
        stray_rr      = 1'b1;
        bad           = 0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            stray_rr = 1'b0;
            if ({busy, lsu_read_ready, lsu_write_ready} != '0) bad++;
        end
        checkOutput("rst_late_ready_ignored", bad, 0);
        exp_n = 0;
        applyStimulus(2, 1'b0, 15'h0010, 8'h00);
        expectTxn(2, 1'b0, 15'h0010, 8'h00, 8'hA5);
        runSequence(1, 1'b0);

        $display("[TB] continuous requests from threads 0 and 3");
        doReset();
        exp_n = 0;
        applyStimulus(0, 1'b0, 15'h0000, 8'h00);
        applyStimulus(3, 1'b0, 15'h0003, 8'h00);
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) expectTxn(0, 1'b0, 15'h0000, 8'h00, 8'h10);
            else            expectTxn(3, 1'b0, 15'h0003, 8'h00, 8'h13);
        end
        runSequence(8, 1'b1);
        lsu_read_valid = '0;

        $display("[TB] randomized rounds against reference model");
        doReset();
        model_ptr = 0;
        for (int r = 0; r < 25; r++) begin
            rm = 4'($urandom);
            wm = 4'($urandom);
            if ((rm | wm) == '0) rm = 4'b0001;
            for (int t = 0; t < NT; t++) begin
                rnd_raddr[t] = pickAddr();
                rnd_waddr[t] = pickAddr();
                rnd_wdata[t] = 8'($urandom);
                if (rm[t]) applyStimulus(t, 1'b0, rnd_raddr[t], 8'h00);
                if (wm[t]) applyStimulus(t, 1'b1, rnd_waddr[t], rnd_wdata[t]);
            end
            modelRound(rm, wm);
            runSequence(exp_n, 1'b0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/core_lsu_arbiter.md
Name: core_lsu_arbiter

Overview:
- Per-core arbiter between NUM_THREADS LSUs and the single-port L1 core local memory (32KB, byte data, one-cycle registered read_ready/write_ready).
- Grants one LSU request at a time, round-robin.
- Drives the memory's read/write strobes as one-cycle pulses and returns data/ready to the granted LSU.
- Includes a response watchdog so a lost memory response cannot hang the core.

Parameters:
- NUM_THREADS, 4, number of LSU requesters
- ADDR_WIDTH, 15, L1 byte address width
- DATA_WIDTH, 8, data width
- TIMEOUT_CYCLES, 8, max WAIT cycles before forced error completion (1..255)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- lsu_read_valid  input  NUM_THREADS  per-thread read request, held until its ready
- lsu_read_address  input  NUM_THREADS*ADDR_WIDTH  thread i at slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- lsu_write_valid  input  NUM_THREADS  per-thread write request, held until its ready
- lsu_write_address  input  NUM_THREADS*ADDR_WIDTH  per-thread write address
- lsu_write_data  input  NUM_THREADS*DATA_WIDTH  per-thread write data
- lsu_read_ready  output  NUM_THREADS  one-cycle read completion pulse
- lsu_read_data  output  NUM_THREADS*DATA_WIDTH  per-thread read data, held until next read completion for that thread
- lsu_write_ready  output  NUM_THREADS  one-cycle write completion pulse
- mem_read_valid  output  1  to L1 read_valid
- mem_read_address  output  ADDR_WIDTH  to L1 read_address
- mem_write_valid  output  1  to L1 write_valid
- mem_write_address  output  ADDR_WIDTH  to L1 write_address
- mem_write_data  output  DATA_WIDTH  to L1 write_data
- mem_read_ready  input  1  from L1
- mem_read_data  input  DATA_WIDTH  from L1
- mem_write_ready  input  1  from L1
- busy  output  1  high in any state except IDLE
- timeout_error  output  1  sticky; set on watchdog expiry, cleared only by reset

Behaviour:
- Reset:
  - All outputs 0, lsu_read_data all 0.
  - State IDLE, rr_ptr=0, watchdog=0.
  - Any L1 response arriving after reset is ignored.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Request vector req[i] = lsu_read_valid[i] | lsu_write_valid[i].
  - Winner = first set bit scanning rr_ptr, rr_ptr+1, ... modulo NUM_THREADS.
  - Latch winner index, op (write if lsu_write_valid[winner], else read), address and data.
  - rr_ptr <= winner+1 (wraps to 0 after NUM_THREADS-1).
  - Go to ISSUE. No request: stay in IDLE.
- Write priority: if a thread asserts both valids, the write is served first. The read is served in a later, separately arbitrated transaction.
- ISSUE (exactly one cycle):
  - Exactly one of mem_read_valid / mem_write_valid is high, with latched address/data.
  - Strobes are never high in any other state.
  - Next state WAIT, watchdog cleared.
- WAIT:
  - On the mem ready matching the latched op, capture mem_read_data (read) and go to DONE.
  - A non-matching ready is ignored.
  - Otherwise watchdog increments; when watchdog==TIMEOUT_CYCLES, set timeout_error and go to DONE with read data forced to 0.
- DONE (one cycle):
  - lsu_read_ready[winner] or lsu_write_ready[winner] high for this cycle only.
  - lsu_read_data slice for winner updated on entry to DONE.
  - Next state IDLE.
- LSU contract: an LSU deasserts valid on the edge where it samples ready high, so the IDLE cycle after DONE already sees it low.
  - A requester that violates this is re-arbitrated normally and served again; no masking is done.
- Valid dropped mid-transaction: the transaction completes and the ready pulse is still issued.
- Latency and throughput:
  - Uncontended: valid sampled in IDLE at cycle 0; mem strobe at cycle 1; L1 ready at cycle 2; LSU ready pulse at cycle 3.
  - One transaction per 4 cycles.
- Fairness: with all threads requesting continuously, each thread is granted once per NUM_THREADS transactions.
- Reset mid-transaction: immediate return to IDLE; no ready pulse is issued for the aborted request.

Test Plan:
- Thread 2 write addr 0x0010 data 0xA5, then read 0x0010 -> write: mem_write_valid pulses at cycle 1, lsu_write_ready[2] at cycle 3; read: lsu_read_data[2]=0xA5 with lsu_read_ready[2] pulse 3 cycles after its valid.
- All 4 threads read simultaneously from reset (addrs 0,1,2,3 preloaded 0x10..0x13) -> grants in order 0,1,2,3, ready pulses 4 cycles apart; each slice holds its own byte.
- Thread 1 asserts both read and write to addr 0x7FFF (data 0x3C) -> write served first, then read returns 0x3C; mem valids are never high together.
- Memory model withholds ready for read -> after 8 WAIT cycles, lsu_read_ready pulses with data 0 and timeout_error=1, sticky until reset.
- Assert reset during WAIT -> next cycle busy=0 and no lsu ready pulse; L1 ready arriving after reset is ignored; the next request completes normally.
- Continuous requests from threads 0 and 3 only -> alternating grants 0,3,0,3; mem strobes are single-cycle pulses throughout.
